// File: rtl/intprepnorm.sv
// ---------------------------------------------------------------------------
// intprepnorm -- iterative integer-to-float operand front end
//
// Purpose:
//   Takes an XLEN-bit or 32-bit integer operand and extracts its sign.
//   Forms the absolute value, then left-normalises it over several cycles
//   while counting leading zeros. The normalised magnitude, sign,
//   leading-zero count and zero flag go to the int-to-float
//   rounding/exponent stage over a valid/ready handshake.
//
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   Flush     in   synchronous abort of any operation in flight
//   InValid   in   operand valid
//   InReady   out  block can accept an operand
//   Int       in   [XLEN-1:0] integer operand
//   Signed    in   operand is two's complement
//   Int64     in   1: use all XLEN bits, 0: use Int[31:0] only
//   OutValid  out  result valid
//   OutReady  in   consumer accepts result
//   Xs        out  result sign
//   Zero      out  operand was zero
//   Lzc       out  [LOGXLEN-1:0] leading zeros of magnitude within XLEN bits
//   Mant      out  [XLEN-1:0] normalised magnitude (MSB set unless Zero)
//
// Configuration macro:
//   INTPREPNORM_BYTESKIP_EN  when defined, NORM shifts by 8 whenever the top
//                            byte is clear. This cuts worst-case occupancy
//                            from 64 cycles to 15. Results are identical
//                            either way; only the latency changes.
// ---------------------------------------------------------------------------
module intprepnorm #(
    parameter int XLEN    = 64,
    parameter int LOGXLEN = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               Flush,
    input  logic               InValid,
    output logic               InReady,
    input  logic [XLEN-1:0]    Int,
    input  logic               Signed,
    input  logic               Int64,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               Xs,
    output logic               Zero,
    output logic [LOGXLEN-1:0] Lzc,
    output logic [XLEN-1:0]    Mant
);

`ifdef INTPREPNORM_BYTESKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ABS  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [XLEN-1:0]    int_q,       int_d;
    logic               signed_q,    signed_d;
    logic               int64_q,     int64_d;
    logic               xs_q,        xs_d;
    logic               zero_q,      zero_d;
    logic [LOGXLEN-1:0] lzc_q,       lzc_d;
    logic [XLEN-1:0]    mant_q,      mant_d;
    logic               out_valid_q, out_valid_d;

    // Operand conditioning for the ABS cycle.
    logic [XLEN-1:0] op_sel;    // operand at the selected width, zero-extended
    logic            sign_bit;  // MSB of the selected width
    logic [XLEN-1:0] op_neg;    // negation at the selected width, zero-extended
    logic            abs_xs;
    logic [XLEN-1:0] abs_mag;

    generate
        if (XLEN > 32) begin : g_wide
            logic [31:0] neg32;
            always_comb begin
                // A 32-bit operand is negated at 32 bits and then
                // zero-extended. Negating the zero-extended value would
                // fill the upper half with ones.
                neg32    = (~Int_low(int_q)) + 32'd1;
                op_sel   = int64_q ? int_q : {{(XLEN-32){1'b0}}, int_q[31:0]};
                sign_bit = int64_q ? int_q[XLEN-1] : int_q[31];
                op_neg   = int64_q ? ((~int_q) + {{(XLEN-1){1'b0}}, 1'b1})
                                   : {{(XLEN-32){1'b0}}, neg32};
            end
        end else begin : g_narrow
            always_comb begin
                op_sel   = int_q;
                sign_bit = int_q[XLEN-1];
                op_neg   = (~int_q) + {{(XLEN-1){1'b0}}, 1'b1};
            end
        end
    endgenerate

    function automatic logic [31:0] Int_low(input logic [XLEN-1:0] v);
        return v[31:0];
    endfunction

    // The most-negative value negates to itself. Read as unsigned, that is
    // the correct magnitude 2^(w-1), so no overflow handling is needed.
    always_comb begin
        abs_xs  = signed_q & sign_bit;
        abs_mag = abs_xs ? op_neg : op_sel;
    end

    assign InReady  = (state_q == S_IDLE) & ~Flush;
    assign OutValid = out_valid_q;
    assign Xs       = xs_q;
    assign Zero     = zero_q;
    assign Lzc      = lzc_q;
    assign Mant     = mant_q;

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        int_d       = int_q;
        signed_d    = signed_q;
        int64_d     = int64_q;
        xs_d        = xs_q;
        zero_d      = zero_q;
        lzc_d       = lzc_q;
        mant_d      = mant_q;
        out_valid_d = out_valid_q;

        if (Flush) begin
            // Abort: drop valid and return to IDLE. Result registers hold
            // their values.
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (InValid) begin
                        int_d    = Int;
                        signed_d = Signed;
                        int64_d  = Int64;
                        state_d  = S_ABS;
                    end
                end

                S_ABS: begin
                    lzc_d = '0;
                    if (abs_mag == '0) begin
                        // Zero needs no normalisation. Zero is reported as
                        // unsigned.
                        xs_d        = 1'b0;
                        zero_d      = 1'b1;
                        mant_d      = '0;
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        xs_d    = abs_xs;
                        zero_d  = 1'b0;
                        mant_d  = abs_mag;
                        state_d = S_NORM;
                    end
                end

                S_NORM: begin
                    if (mant_q[XLEN-1]) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end else if (SKIP_EN && (mant_q[XLEN-1 -: 8] == 8'd0)) begin
                        // The top byte is clear, so the leading one lies
                        // below it. A full byte shift cannot overshoot.
                        mant_d = {mant_q[XLEN-9:0], 8'd0};
                        lzc_d  = lzc_q + LOGXLEN'(8);
                    end else begin
                        mant_d = {mant_q[XLEN-2:0], 1'b0};
                        lzc_d  = lzc_q + LOGXLEN'(1);
                    end
                end

                S_DONE: begin
                    if (OutReady) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                    end
                end

                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            int_q       <= '0;
            signed_q    <= 1'b0;
            int64_q     <= 1'b0;
            xs_q        <= 1'b0;
            zero_q      <= 1'b0;
            lzc_q       <= '0;
            mant_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_q       <= int_d;
            signed_q    <= signed_d;
            int64_q     <= int64_d;
            xs_q        <= xs_d;
            zero_q      <= zero_d;
            lzc_q       <= lzc_d;
            mant_q      <= mant_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_intprepnorm.sv
`timescale 1ns/1ps
module tb_intprepnorm;
    localparam int XLEN    = 64;
    localparam int LOGXLEN = 6;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               Flush;
    logic               InValid;
    logic               InReady;
    logic [XLEN-1:0]    Int;
    logic               Signed;
    logic               Int64;
    logic               OutValid;
    logic               OutReady;
    logic               Xs;
    logic               Zero;
    logic [LOGXLEN-1:0] Lzc;
    logic [XLEN-1:0]    Mant;

    intprepnorm #(.XLEN(XLEN), .LOGXLEN(LOGXLEN)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .Int      (Int),
        .Signed   (Signed),
        .Int64    (Int64),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Xs       (Xs),
        .Zero     (Zero),
        .Lzc      (Lzc),
        .Mant     (Mant)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int           id;
        logic         xs;
        logic         zero;
        logic [5:0]   lzc;
        logic [63:0]  mant;
        int           exp_edge;
    } exp_t;

    exp_t sb_q[$];

    function automatic int norm_cycles(input int l, input bit is_zero);
        if (is_zero) return 0;
`ifdef INTPREPNORM_BYTESKIP_EN
        return l / 8 + l % 8 + 1;
`else
        return l + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard when a result first appears, then checks
    // that it stays stable while the consumer stalls.
    initial begin : monitor
        exp_t cur;
        bit   seen  = 1'b0;
        bit   bogus = 1'b0;
        forever begin
            @(negedge clk);
            if (OutValid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb_q.size() == 0) begin
                        bogus = 1'b1;
                        n_assert++;
                        n_fail++;
                        $display("FAIL unexpected_out: actual OutValid=1 Mant=0x%0h required no pending result", Mant);
                    end else begin
                        bogus = 1'b0;
                        cur = sb_q.pop_front();
                        check($sformatf("op%0d_xs", cur.id),      Xs,       cur.xs);
                        check($sformatf("op%0d_zero", cur.id),    Zero,     cur.zero);
                        check($sformatf("op%0d_lzc", cur.id),     Lzc,      cur.lzc);
                        check($sformatf("op%0d_mant", cur.id),    Mant,     cur.mant);
                        check($sformatf("op%0d_latency", cur.id), edge_cnt, cur.exp_edge);
                        check($sformatf("op%0d_inready", cur.id), InReady,  1'b0);
                        $display("result op%0d: Xs=%0b Zero=%0b Lzc=%0d Mant=0x%016h at edge %0d",
                                 cur.id, Xs, Zero, Lzc, Mant, edge_cnt);
                    end
                end else if (!bogus) begin
                    check($sformatf("op%0d_hold_xs", cur.id),      Xs,      cur.xs);
                    check($sformatf("op%0d_hold_zero", cur.id),    Zero,    cur.zero);
                    check($sformatf("op%0d_hold_lzc", cur.id),     Lzc,     cur.lzc);
                    check($sformatf("op%0d_hold_mant", cur.id),    Mant,    cur.mant);
                    check($sformatf("op%0d_hold_inready", cur.id), InReady, 1'b0);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic send(input int id, input logic [63:0] v, input logic s, input logic i64,
                        input bit push, input logic xs, input logic zero,
                        input logic [5:0] lzc, input logic [63:0] mant);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (InReady !== 1'b1) begin
            waited++;
            if (waited > 300) begin
                n_assert++;
                n_fail++;
                $display("FAIL op%0d_accept_timeout: actual InReady=%0b required 1", id, InReady);
                return;
            end
            @(negedge clk);
        end
        Int     = v;
        Signed  = s;
        Int64   = i64;
        InValid = 1'b1;
        @(posedge clk);
        #1;
        InValid = 1'b0;
        $display("issue op%0d: Int=0x%016h Signed=%0b Int64=%0b accepted at edge %0d%s",
                 id, v, s, i64, edge_cnt, push ? "" : " (no result expected)");
        if (push) begin
            e.id       = id;
            e.xs       = xs;
            e.zero     = zero;
            e.lzc      = lzc;
            e.mant     = mant;
            e.exp_edge = edge_cnt + 1 + norm_cycles(int'(lzc), zero);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int waited = 0;
        @(negedge clk);
        while (!(sb_q.size() == 0 && OutValid === 1'b0 && InReady === 1'b1)) begin
            waited++;
            if (waited > 300) begin
                n_assert++;
                n_fail++;
                $display("FAIL %s_drain_timeout: actual pending=%0d required 0", name, sb_q.size());
                sb_q.delete();
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int waited;
        reset_n  = 1'b0;
        Flush    = 1'b0;
        InValid  = 1'b0;
        Int      = '0;
        Signed   = 1'b0;
        Int64    = 1'b0;
        OutReady = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outvalid", OutValid, 1'b0);
        check("reset_xs",       Xs,       1'b0);
        check("reset_zero",     Zero,     1'b0);
        check("reset_lzc",      Lzc,      6'd0);
        check("reset_mant",     Mant,     64'd0);
        reset_n = 1'b1;
        #1;
        check("reset_inready", InReady, 1'b1);

        // Directed vectors with hand-computed results.
        send(1,  64'h0000_0000_0000_0001, 1, 1, 1, 0, 0, 6'd63, 64'h8000_0000_0000_0000);
        send(2,  64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 1, 0, 6'd63, 64'h8000_0000_0000_0000);
        send(3,  64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 0, 0, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF);
        send(4,  64'h8000_0000_0000_0000, 1, 1, 1, 1, 0, 6'd0,  64'h8000_0000_0000_0000);
        send(5,  64'h0000_0000_FFFF_FFFF, 1, 0, 1, 1, 0, 6'd63, 64'h8000_0000_0000_0000);
        send(6,  64'hFFFF_FFFF_8000_0000, 1, 0, 1, 1, 0, 6'd32, 64'h8000_0000_0000_0000);
        send(7,  64'hDEAD_BEEF_1234_5678, 0, 0, 1, 0, 0, 6'd35, 64'h91A2_B3C0_0000_0000);
        send(8,  64'hFFFF_FFFF_FFFF_FFFB, 1, 1, 1, 1, 0, 6'd61, 64'hA000_0000_0000_0000);
        send(9,  64'h0000_0000_0001_0000, 0, 1, 1, 0, 0, 6'd47, 64'h8000_0000_0000_0000);
        send(10, 64'hABCD_0000_FFFF_FFFF, 0, 0, 1, 0, 0, 6'd32, 64'hFFFF_FFFF_0000_0000);
        drain("vectors");

        // Zero operand; the consumer stalls for 5 cycles.
        OutReady = 1'b0;
        send(11, 64'h0, 1, 1, 1, 0, 1, 6'd0, 64'h0);
        waited = 0;
        @(negedge clk);
        while (OutValid !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        OutReady = 1'b1;
        drain("zero");

        // Reset pulse while normalisation is in progress.
        send(12, 64'h0000_0000_0001_0000, 0, 1, 0, 0, 0, 6'd47, 64'h0);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset_outvalid", OutValid, 1'b0);
        check("midreset_xs",       Xs,       1'b0);
        check("midreset_zero",     Zero,     1'b0);
        check("midreset_lzc",      Lzc,      6'd0);
        check("midreset_mant",     Mant,     64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midreset_inready", InReady, 1'b1);
        repeat (70) @(negedge clk);

        // Flush while normalisation is in progress: no result may appear.
        send(13, 64'h0000_0000_0001_0000, 0, 1, 0, 0, 0, 6'd47, 64'h0);
        repeat (4) @(negedge clk);
        Flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Flush = 1'b0;
        #1;
        check("flush_norm_inready",  InReady,  1'b1);
        check("flush_norm_outvalid", OutValid, 1'b0);
        repeat (70) @(negedge clk);
        check("flush_norm_quiet", OutValid, 1'b0);

        // Flush together with InValid in IDLE: the operand is refused.
        @(negedge clk);
        Flush   = 1'b1;
        InValid = 1'b1;
        Int     = 64'd5;
        Signed  = 1'b0;
        Int64   = 1'b1;
        #1;
        check("flush_idle_inready", InReady, 1'b0);
        @(posedge clk);
        @(negedge clk);
        Flush   = 1'b0;
        InValid = 1'b0;
        #1;
        check("flush_idle_not_taken", InReady, 1'b1);
        repeat (3) @(negedge clk);
        check("flush_idle_no_out", OutValid, 1'b0);

        send(14, 64'd5, 0, 1, 1, 0, 0, 6'd61, 64'hA000_0000_0000_0000);
        drain("after_flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/intprepnorm.md
# intprepnorm

Iterative integer-to-float front end for the FPU conversion path: the operand-side counterpart of the float-to-int result negation stage. Accepts an XLEN or 32-bit integer, extracts the sign, takes the absolute value, then left-normalizes it over multiple cycles while counting leading zeros. Hands the normalized magnitude, sign, leading-zero count and zero flag to the int-to-float rounding/exponent logic over a valid/ready handshake.

## Interface
- XLEN, 64, integer datapath width (32 or 64)
- LOGXLEN, $clog2(XLEN), width of leading-zero count
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous abort; discards any operation in flight
- InValid  in  1  operand valid
- InReady  out  1  block can accept an operand
- Int  in  XLEN  integer operand
- Signed  in  1  operand is two's complement
- Int64  in  1  1: use all XLEN bits; 0: use Int[31:0] only
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- Xs  out  1  result sign
- Zero  out  1  operand was zero
- Lzc  out  LOGXLEN  leading zeros of magnitude within XLEN bits
- Mant  out  XLEN  normalized magnitude; Mant[XLEN-1]=1 unless Zero

## Operation
- States: IDLE, ABS, NORM, DONE. InReady = (state==IDLE) & ~Flush.
- IDLE: on InValid&InReady, capture Int/Signed/Int64 -> ABS.
- ABS (1 cycle): Op = Int64 ? Int : {XLEN-32 zeros, Int[31:0]}. Sign bit = Int64 ? Int[XLEN-1] : Int[31]. Xs = Signed & sign bit. Magnitude = Xs ? two's-complement negation of the selected width (32-bit negation zero-extended when Int64=0) : Op. Most-negative value yields unsigned 2^(w-1); no overflow. Magnitude==0 -> Zero=1, Mant=0, Lzc=0, Xs=0 -> DONE; else Lzc=0 -> NORM.
- NORM, per cycle: if Mant[XLEN-1]=1 -> DONE (no shift). Else if skip enabled (see Configuration) and Mant[XLEN-1:XLEN-8]==0: Mant<<=8, Lzc+=8. Else Mant<<=1, Lzc+=1.
- DONE: OutValid=1; outputs stable until OutValid&OutReady, then -> IDLE. No new operand accepted until IDLE.
- Flush: any state -> IDLE next edge; OutValid drops; outputs otherwise unchanged. Flush with InValid in IDLE: operand not accepted.
- reset_n low (any time, including mid-NORM): immediately state=IDLE; OutValid, Xs, Zero, Lzc, Mant all 0; InReady=1 once released.

## Timing
- Accept at end of cycle k; ABS in cycle k+1; NORM starts cycle k+2.
- L = leading zeros of magnitude. NORM occupancy N = floor(L/8)+(L mod 8)+1 with skip, L+1 without.
- OutValid first high in cycle k+2+N; zero operand: cycle k+2.
- Back-to-back: next InReady earliest the cycle after the OutValid&OutReady edge.
- All outputs registered; no combinational path input->output except InReady from Flush.

## Configuration
- INTPREPNORM_BYTESKIP_EN defined: 8-bit skip step in NORM, worst case (L=XLEN-1=63) N=15.
- Undefined: 1-bit step only, worst case N=64; Mant/Lzc results identical, only latency differs.

## Test plan
- Int=1, Signed=1, Int64=1: Xs=0, Lzc=63, Mant=0x8000_0000_0000_0000; OutValid at k+17 (skip) / k+66 (no skip).
- Int=0xFFFF_FFFF_FFFF_FFFF, Signed=1, Int64=1: Xs=1, Lzc=63, Mant=0x8000...0; same Signed=0: Xs=0, Lzc=0, Mant=all ones, OutValid k+3.
- Int=0x8000_0000_0000_0000, Signed=1, Int64=1: Xs=1, Lzc=0, Mant=0x8000...0, OutValid k+3; Int=0x0000_0000_FFFF_FFFF, Int64=0, Signed=1: Xs=1, Lzc=63.
- Int=0: Zero=1, Mant=0, Lzc=0, Xs=0, OutValid at k+2; hold OutReady=0 5 cycles -> outputs stable, InReady=0.
- Int=0x0000_0000_0001_0000 in NORM, reset_n pulsed low mid-NORM -> all outputs 0, InReady=1; Flush mid-NORM -> IDLE next cycle, OutValid never asserted.
- Flush=1 with InValid=1 in IDLE -> not accepted; next operand after Flush processes normally.
